// File: rtl/buzzer_poly_if.sv
// buzzer_poly_if: command strobe/word from the CPU and tone/status back to it
interface buzzer_poly_if #(
  parameter int CHANNELS = 4
);
  logic start;
  logic [23:0] in;
  logic sound;
  logic [CHANNELS-1:0] active;
  logic cmd_err;
  modport master(output start, in, input sound, active, cmd_err);
  modport slave(input start, in, output sound, active, cmd_err);
endinterface

// File: rtl/buzzer_poly.sv
// buzzer_poly: multi-channel square-wave tone generator with PWM volume, duration timers and OR mixing
module buzzer_poly #(
  parameter int CHANNELS = 4,
  parameter int PERIOD_W = 12,
  parameter int VOL_W = 2,
  parameter int PRESC = 64,
  parameter int DUR_SHIFT = 10
) (
  input logic clk,
  input logic rst,
  buzzer_poly_if.slave bus
);
  localparam int PW = PRESC > 1 ? $clog2(PRESC) : 1;
  localparam int DW = 16 + DUR_SHIFT;
  localparam logic [3:0] OP_SET = 4'd1;
  localparam logic [3:0] OP_STOP = 4'd2;
  localparam logic [3:0] OP_VOL = 4'd3;
  localparam logic [3:0] OP_DUR = 4'd4;
  localparam logic [3:0] OP_STOPALL = 4'd5;
  logic [3:0] op, ch;
  logic [15:0] pl;
  logic [PW-1:0] presc;
  logic [VOL_W-1:0] pwm;
  logic tick, bad, go, sound, cmd_err;
  logic [CHANNELS-1:0] ch_out, active;
  assign op = bus.in[23:20];
  assign ch = bus.in[19:16];
  assign pl = bus.in[15:0];
  assign tick = presc == PW'(PRESC - 1);
  // STOPALL ignores the channel field, so only opcodes 1..4 are range-checked
  assign bad = bus.start & ((op > OP_STOPALL) | ((op >= OP_SET) & (op <= OP_DUR) & (int'(ch) >= CHANNELS)));
  assign go = bus.start & ~bad;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [PERIOD_W-1:0] per, cnt;
    logic [VOL_W-1:0] vol;
    logic [DW-1:0] dur;
    logic phase, hit, wrap;
    assign hit = go & (ch == 4'(c));
    assign wrap = cnt == per - PERIOD_W'(1);
    // later assignments are commands, so they win over tone and expiry updates on the same edge
    always_ff @(posedge clk) begin
      if (rst) begin
        per <= '0;
        cnt <= '0;
        phase <= 1'b0;
        vol <= '1;
        dur <= '0;
      end else begin
        cnt <= ~|per ? '0 : tick ? (wrap ? '0 : cnt + PERIOD_W'(1)) : cnt;
        phase <= |per & (phase ^ (tick & wrap));
        if (|dur & |per) dur <= dur - DW'(1);
        if ((dur == DW'(1)) & |per) per <= '0;
        if ((hit & (op == OP_STOP)) | (go & (op == OP_STOPALL))) begin
          per <= '0;
          dur <= '0;
        end
        if (hit & (op == OP_SET)) begin
          per <= pl[PERIOD_W-1:0];
          cnt <= '0;
          phase <= 1'b0;
        end
        if (hit & (op == OP_VOL)) vol <= pl[VOL_W-1:0];
        if (hit & (op == OP_DUR)) dur <= DW'(pl) << DUR_SHIFT;
      end
    end
    assign ch_out[c] = phase & (&vol | (pwm < vol)) & |per;
    assign active[c] = |per;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      pwm <= '0;
      sound <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      pwm <= pwm + VOL_W'(1);
      sound <= |ch_out;
      cmd_err <= bad;
    end
  end
  assign bus.sound = sound;
  assign bus.active = active;
  assign bus.cmd_err = cmd_err;
endmodule
